mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port memory arbiter between the cpu16 instruction/data ports, the SPI debug write port, and the shared sram/vram/ctrl write-read bus.
- Replaces the top-level "never deny" rdy shim with real arbitration.
- Debug writes always win.
- Instruction and data requests alternate round-robin when both are pending.
- Read data returns one cycle after grant, with the requester's rdy.

Parameters:
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock (sys_clk domain)
- reset_n  in  1  asynchronous active-low reset
- dbg_we  in  1  debug write strobe, single-cycle, no backpressure
- dbg_waddr  in  AW  debug write address
- dbg_wdata  in  DW  debug write data
- ins_rd_req  in  1  cpu instruction read request, held until ins_rd_rdy
- ins_rd_addr  in  AW  instruction address
- ins_rd_rdy  out  1  instruction read complete, data valid this cycle
- ins_rd_data  out  DW  instruction read data
- dat_rd_req  in  1  cpu data read request, held until dat_rd_rdy
- dat_wr_req  in  1  cpu data write request, held until dat_wr_rdy
- dat_rw_addr  in  AW  data address
- dat_wr_data  in  DW  data write data
- dat_rd_rdy  out  1  data read complete
- dat_wr_rdy  out  1  data write complete
- dat_rd_data  out  DW  data read data
- mem_addr  out  AW  shared bus address (combinational, grant cycle)
- mem_wdata  out  DW  shared bus write data
- mem_we  out  1  shared bus write enable
- mem_re  out  1  shared bus read enable
- mem_rdata  in  DW  memory read data, valid the cycle after mem_re

Behaviour:
- Grant is evaluated combinationally every cycle N. Priority:
  1. dbg_we
  2. the round-robin pick between eligible ins and dat requests
  3. idle
- Eligibility:
  - A requester granted in cycle N is ineligible in cycle N+1. Its req is still high for the same transaction during the rdy cycle.
  - A req still high in N+2 is a new transaction.
- Data-port conflict: dat_rd_req and dat_wr_req together is a protocol violation. Treat it as a write; dat_rd_rdy stays low.
- Round-robin:
  - A 1-bit last_grant register is updated only on cpu grants.
  - When both ins and dat are eligible, the one not served last wins.
  - A single eligible requester wins regardless of last_grant.
  - last_grant resets to "dat", so ins wins the first tie.
- Debug grant: mem_addr=dbg_waddr, mem_wdata=dbg_wdata, mem_we=1, mem_re=0. The debug write is never stalled or dropped. A cpu requester losing to debug stays pending and retries next cycle.
- Ins grant: mem_addr=ins_rd_addr, mem_re=1, mem_we=0.
- Dat read grant: mem_addr=dat_rw_addr, mem_re=1.
- Dat write grant: mem_addr=dat_rw_addr, mem_wdata=dat_wr_data, mem_we=1.
- Idle: mem_we=0, mem_re=0. mem_addr and mem_wdata are don't-care but must be driven from the dat port (no X).
- Completion (rdy signals are registered):
  - Grant in N gives the matching *_rdy =1 for exactly cycle N+1.
  - At most one rdy is high per cycle.
  - Write completion (dat_wr_rdy) means the write was presented to memory in N.
- Read data:
  - In the rdy cycle, ins_rd_data/dat_rd_data = mem_rdata (pass-through).
  - At the end of the rdy cycle, the value is captured into a per-port hold register.
  - Outside rdy cycles, each data output shows its hold register.
  - Hold registers reset to 0.
- Throughput:
  - Each cpu port completes at most 1 transaction per 2 cycles.
  - ins and dat interleaved fill the bus every cycle.
  - Debug traffic steals cycles.
- Reset (reset_n low, asynchronous, any cycle including mid-transaction):
  - Outputs: all rdy=0, data outputs 0, mem_we=0, mem_re=0.
  - State: busy flags clear, last_grant=dat.
  - An in-flight transaction is abandoned with no rdy. The requester re-issues after release.
- Release: first grant possible in the first clk edge after reset_n rises.

Test Plan:
- Reset then ins_rd_req=1, addr 0x0010, mem returns 0x1234 → mem_re in cycle 0; ins_rd_rdy=1 and ins_rd_data=0x1234 in cycle 1; no re-grant in cycle 1; re-grant cycle 2 if req held.
- ins and dat_rd both held continuously → grants alternate ins,dat,ins,dat with mem_re every cycle; rdy alternates; no port starves.
- dbg_we pulse addr 0xF000 data 0x0001 during contending cpu reqs → that cycle mem_we=1, mem_addr=0xF000, mem_wdata=0x0001; cpu grants slip one cycle; no rdy in following cycle for cpu.
- dat_wr_req addr 0x8005 data 0x0041 → mem_we=1 cycle 0, dat_wr_rdy=1 cycle 1, dat_rd_rdy stays 0; with dat_rd_req also high same result.
- dat read returns 0xBEEF, then idle with mem_rdata=0x0000 → dat_rd_data stays 0xBEEF; ins_rd_data unchanged.
- reset_n asserted in the cycle after an ins grant → ins_rd_rdy never pulses, outputs 0 immediately; after release with ins and dat tied, ins wins first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared-bus arbiter interface: cpu ins/data ports, debug write port
// and the single-port memory bus, bundled with arbiter/environment views.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          dbg_we;
  logic [AW-1:0] dbg_waddr;
  logic [DW-1:0] dbg_wdata;

  logic          ins_rd_req;
  logic [AW-1:0] ins_rd_addr;
  logic          ins_rd_rdy;
  logic [DW-1:0] ins_rd_data;

  logic          dat_rd_req;
  logic          dat_wr_req;
  logic [AW-1:0] dat_rw_addr;
  logic [DW-1:0] dat_wr_data;
  logic          dat_rd_rdy;
  logic          dat_wr_rdy;
  logic [DW-1:0] dat_rd_data;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  dbg_we, dbg_waddr, dbg_wdata,
    input  ins_rd_req, ins_rd_addr,
    output ins_rd_rdy, ins_rd_data,
    input  dat_rd_req, dat_wr_req,
    input  dat_rw_addr, dat_wr_data,
    output dat_rd_rdy, dat_wr_rdy, dat_rd_data,
    output mem_addr, mem_wdata,
    output mem_we, mem_re,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output dbg_we, dbg_waddr, dbg_wdata,
    output ins_rd_req, ins_rd_addr,
    input  ins_rd_rdy, ins_rd_data,
    output dat_rd_req, dat_wr_req,
    output dat_rw_addr, dat_wr_data,
    input  dat_rd_rdy, dat_wr_rdy, dat_rd_data,
    input  mem_addr, mem_wdata,
    input  mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: debug writes first, then round-robin
// between cpu instruction and data ports; rdy/data one cycle after grant.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic clk,
  input  logic reset_n,
  mem_arbiter_if.slave io
);

  logic          ins_rdy_q;
  logic          dat_rd_rdy_q;
  logic          dat_wr_rdy_q;
  logic [DW-1:0] ins_hold_q;
  logic [DW-1:0] dat_hold_q;
  logic          last_dat_q;
  logic          last_dat_d;

  logic          ins_elig;
  logic          dat_req;
  logic          dat_elig;
  logic          dat_busy;
  logic          gnt_dbg;
  logic          gnt_ins;
  logic          gnt_dat;

  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_we;
  logic          bus_re;

  // A port granted last cycle is in its rdy cycle and must not re-win
  always_comb begin
    dat_req  = io.dat_rd_req | io.dat_wr_req;
    dat_busy = dat_rd_rdy_q | dat_wr_rdy_q;
    ins_elig = io.ins_rd_req & ~ins_rdy_q;
    dat_elig = dat_req & ~dat_busy;
  end

  // Grant: debug, then round-robin; nothing while reset is held
  always_comb begin
    gnt_dbg = 1'b0;
    gnt_ins = 1'b0;
    gnt_dat = 1'b0;
    if (!reset_n) begin
      gnt_dbg = 1'b0;
    end else if (io.dbg_we) begin
      gnt_dbg = 1'b1;
    end else if (ins_elig && dat_elig) begin
      gnt_ins = last_dat_q;
      gnt_dat = ~last_dat_q;
    end else begin
      gnt_ins = ins_elig;
      gnt_dat = dat_elig;
    end
  end

  // Round-robin pointer only moves on cpu grants
  always_comb begin
    last_dat_d = last_dat_q;
    unique case (1'b1)
      gnt_ins: last_dat_d = 1'b0;
      gnt_dat: last_dat_d = 1'b1;
      default: last_dat_d = last_dat_q;
    endcase
  end

  // Bus mux; idle cycles still drive the data port to avoid X
  always_comb begin
    bus_addr  = io.dat_rw_addr;
    bus_wdata = io.dat_wr_data;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    unique case (1'b1)
      gnt_dbg: begin
        bus_addr  = io.dbg_waddr;
        bus_wdata = io.dbg_wdata;
        bus_we    = 1'b1;
      end
      gnt_ins: begin
        bus_addr = io.ins_rd_addr;
        bus_re   = 1'b1;
      end
      gnt_dat: begin
        bus_we = io.dat_wr_req;
        bus_re = ~io.dat_wr_req;
      end
      default: begin
        bus_we = 1'b0;
        bus_re = 1'b0;
      end
    endcase
  end

  // Completion flags; a simultaneous rd+wr is served as a write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins_rdy_q    <= 1'b0;
      dat_rd_rdy_q <= 1'b0;
      dat_wr_rdy_q <= 1'b0;
      last_dat_q   <= 1'b1;
    end else begin
      ins_rdy_q    <= gnt_ins;
      dat_rd_rdy_q <= gnt_dat & ~io.dat_wr_req;
      dat_wr_rdy_q <= gnt_dat & io.dat_wr_req;
      last_dat_q   <= last_dat_d;
    end
  end

  // Capture read data at the end of each rdy cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins_hold_q <= '0;
      dat_hold_q <= '0;
    end else begin
      if (ins_rdy_q) ins_hold_q <= io.mem_rdata;
      if (dat_rd_rdy_q) dat_hold_q <= io.mem_rdata;
    end
  end

  assign io.mem_addr    = bus_addr;
  assign io.mem_wdata   = bus_wdata;
  assign io.mem_we      = bus_we;
  assign io.mem_re      = bus_re;
  assign io.ins_rd_rdy  = ins_rdy_q;
  assign io.dat_rd_rdy  = dat_rd_rdy_q;
  assign io.dat_wr_rdy  = dat_wr_rdy_q;
  assign io.ins_rd_data = ins_rdy_q ? io.mem_rdata : ins_hold_q;
  assign io.dat_rd_data = dat_rd_rdy_q ? io.mem_rdata : dat_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus
// cycles and completions, negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int P_INS = 0;
  localparam int P_DRD = 1;
  localparam int P_DWR = 2;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_t;

  typedef struct {
    int          port;
    logic [15:0] data;
  } rsp_t;

  logic clk;
  logic reset_n;
  logic [15:0] rd_q;
  int tests;
  int fails;
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h1234;
      16'h0020: return 16'h1111;
      16'h0030: return 16'h2222;
      16'h0040: return 16'hBEEF;
      default:  return 16'hDEAD;
    endcase
  endfunction

  // Memory returns data the cycle after mem_re, zero otherwise
  always @(posedge clk) begin
    rd_q <= bus.mem_re ? mem_val(bus.mem_addr) : 16'h0000;
  end
  assign bus.mem_rdata = rd_q;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_bus(input logic we, input logic re,
                         input logic [15:0] a, input logic [15:0] d);
    bus_t b;
    b.we = we;
    b.re = re;
    b.addr = a;
    b.wdata = d;
    bus_q.push_back(b);
  endtask

  task automatic exp_rsp(input int p, input logic [15:0] d);
    rsp_t r;
    r.port = p;
    r.data = d;
    rsp_q.push_back(r);
  endtask

  // Bus monitor
  always @(negedge clk) begin
    bus_t b;
    if (bus.mem_we || bus.mem_re) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected",
              {bus.mem_we, bus.mem_re, bus.mem_addr}, 32'h0);
      end else begin
        b = bus_q.pop_front();
        check("bus_cycle",
              {bus.mem_we, bus.mem_re, bus.mem_addr},
              {b.we, b.re, b.addr});
        if (b.we) check("bus_wdata", bus.mem_wdata, b.wdata);
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    rsp_t r;
    int n;
    int p;
    logic [15:0] d;
    n = int'(bus.ins_rd_rdy) + int'(bus.dat_rd_rdy)
      + int'(bus.dat_wr_rdy);
    if (n > 1) check("rdy_onehot", n, 1);
    if (n == 1) begin
      p = bus.ins_rd_rdy ? P_INS : bus.dat_rd_rdy ? P_DRD : P_DWR;
      d = p == P_INS ? bus.ins_rd_data :
          p == P_DRD ? bus.dat_rd_data : 16'h0000;
      if (rsp_q.size() == 0) begin
        check("rdy_unexpected", p + 1, 0);
      end else begin
        r = rsp_q.pop_front();
        check("rdy_port", p, r.port);
        if (r.port != P_DWR) check("rdy_data", d, r.data);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    bus.dbg_we = 1'b0;
    bus.dbg_waddr = 16'h0;
    bus.dbg_wdata = 16'h0;
    bus.ins_rd_req = 1'b0;
    bus.ins_rd_addr = 16'h0;
    bus.dat_rd_req = 1'b0;
    bus.dat_wr_req = 1'b0;
    bus.dat_rw_addr = 16'h0;
    bus.dat_wr_data = 16'h0;
    step();
    step();
    check("rst_rdy", {bus.ins_rd_rdy, bus.dat_rd_rdy,
                      bus.dat_wr_rdy}, 0);
    check("rst_data", {bus.ins_rd_data, bus.dat_rd_data}, 0);
    check("rst_bus", {bus.mem_we, bus.mem_re}, 0);

    // 1: single ins read, re-grant only every other cycle
    reset_n = 1'b1;
    bus.ins_rd_req = 1'b1;
    bus.ins_rd_addr = 16'h0010;
    exp_bus(0, 1, 16'h0010, 0);
    step();
    exp_rsp(P_INS, 16'h1234);
    step();
    exp_bus(0, 1, 16'h0010, 0);
    step();
    exp_rsp(P_INS, 16'h1234);
    step();
    bus.ins_rd_req = 1'b0;
    step();

    // 2: ins and dat contend; last served was ins so dat first
    bus.ins_rd_req = 1'b1;
    bus.ins_rd_addr = 16'h0020;
    bus.dat_rd_req = 1'b1;
    bus.dat_rw_addr = 16'h0030;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) exp_bus(0, 1, 16'h0030, 0);
      else exp_bus(0, 1, 16'h0020, 0);
      if (k > 0) begin
        if (k % 2 == 1) exp_rsp(P_DRD, 16'h2222);
        else exp_rsp(P_INS, 16'h1111);
      end
      step();
    end
    bus.dat_rd_req = 1'b0;
    exp_rsp(P_INS, 16'h1111);
    step();
    bus.ins_rd_req = 1'b0;
    step();

    // 3: debug write steals the contended cycle
    bus.ins_rd_req = 1'b1;
    bus.dat_rd_req = 1'b1;
    bus.dbg_we = 1'b1;
    bus.dbg_waddr = 16'hF000;
    bus.dbg_wdata = 16'h0001;
    exp_bus(1, 0, 16'hF000, 16'h0001);
    step();
    bus.dbg_we = 1'b0;
    exp_bus(0, 1, 16'h0030, 0);
    step();
    exp_bus(0, 1, 16'h0020, 0);
    exp_rsp(P_DRD, 16'h2222);
    step();
    bus.dat_rd_req = 1'b0;
    exp_rsp(P_INS, 16'h1111);
    step();
    bus.ins_rd_req = 1'b0;
    step();

    // 4: data write, then write with conflicting read
    bus.dat_wr_req = 1'b1;
    bus.dat_rw_addr = 16'h8005;
    bus.dat_wr_data = 16'h0041;
    exp_bus(1, 0, 16'h8005, 16'h0041);
    step();
    exp_rsp(P_DWR, 0);
    step();
    bus.dat_wr_req = 1'b0;
    step();
    bus.dat_wr_req = 1'b1;
    bus.dat_rd_req = 1'b1;
    exp_bus(1, 0, 16'h8005, 16'h0041);
    step();
    exp_rsp(P_DWR, 0);
    step();
    bus.dat_wr_req = 1'b0;
    bus.dat_rd_req = 1'b0;
    step();
    check("hold_after_wr", bus.dat_rd_data, 16'h2222);

    // 5: read data held after the rdy cycle
    bus.dat_rd_req = 1'b1;
    bus.dat_rw_addr = 16'h0040;
    exp_bus(0, 1, 16'h0040, 0);
    step();
    exp_rsp(P_DRD, 16'hBEEF);
    step();
    bus.dat_rd_req = 1'b0;
    step();
    step();
    check("idle_rdata", bus.mem_rdata, 16'h0000);
    check("dat_hold", bus.dat_rd_data, 16'hBEEF);
    check("ins_hold", bus.ins_rd_data, 16'h1111);

    // 6: reset during the rdy cycle abandons the transaction
    bus.ins_rd_req = 1'b1;
    bus.ins_rd_addr = 16'h0010;
    exp_bus(0, 1, 16'h0010, 0);
    step();
    reset_n = 1'b0;
    bus.dat_rd_req = 1'b1;
    bus.dat_rw_addr = 16'h0030;
    #1;
    check("rst_mid_rdy", bus.ins_rd_rdy, 0);
    check("rst_mid_data", {bus.ins_rd_data, bus.dat_rd_data}, 0);
    check("rst_mid_bus", {bus.mem_we, bus.mem_re}, 0);
    step();
    step();
    reset_n = 1'b1;
    exp_bus(0, 1, 16'h0010, 0);
    step();
    exp_bus(0, 1, 16'h0030, 0);
    exp_rsp(P_INS, 16'h1234);
    step();
    bus.ins_rd_req = 1'b0;
    exp_rsp(P_DRD, 16'h2222);
    step();
    bus.dat_rd_req = 1'b0;
    step();
    step();

    check("bus_q_drained", bus_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
